// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with writeback bypass,
// load-use bubble insertion, back-pressure and flush.
module id_ex_stage #(
   parameter int XLEN        = 64,
   parameter int RA_W        = 5,
   parameter int CTRL_W      = 8,
   parameter int MEMREAD_BIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [RA_W-1:0]   ex_rs1,
   output logic [RA_W-1:0]   ex_rs2,
   output logic [RA_W-1:0]   ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              load_use_stall
);

   logic            adv;
   logic            hazard;
   logic            wb_hit1;
   logic            wb_hit2;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;

   // RF returns the pre-write value in the write cycle, so bypass here.
   function automatic logic [XLEN-1:0] byp(
      input logic [RA_W-1:0] idx,
      input logic [XLEN-1:0] rf
   );
      if (idx == '0)
         return '0;
      else if (wb_we && wb_rd == idx)
         return wb_data;
      else
         return rf;
   endfunction

   assign adv    = !ex_valid | ex_ready;
   assign hazard = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT]
                 & (ex_rd != '0)
                 & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   assign load_use_stall = adv & hazard & !flush;
   assign id_ready       = (adv & !hazard) | flush;

   assign op1 = byp(id_rs1, id_rs1_data);
   assign op2 = byp(id_rs2, id_rs2_data);

   assign wb_hit1 = wb_we & (wb_rd != '0) & (wb_rd == ex_rs1);
   assign wb_hit2 = wb_we & (wb_rd != '0) & (wb_rd == ex_rs2);

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (adv && hazard) begin
         ex_valid <= 1'b0;
      end else if (adv) begin
         ex_valid    <= id_valid;
         ex_rs1_data <= op1;
         ex_rs2_data <= op2;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_ctrl     <= id_ctrl;
      end else begin
         // Held operands keep tracking writeback so they never go stale.
         if (wb_hit1)
            ex_rs1_data <= wb_data;
         if (wb_hit2)
            ex_rs2_data <= wb_data;
      end
   end

endmodule
